// File: rtl/hangy_pkg.sv
// Shared definitions for the hangman input frontend: chip_input field layout
// and the word-index LFSR polynomial.
package hangy_pkg;

  localparam int CHAR_LSB = 0;
  localparam int CHAR_W   = 5;
  localparam int NEXT_BIT = 5;
  localparam int WIDX_LSB = 6;
  localparam int WIDX_W   = 6;
  localparam int CHIP_W   = 12;

  // x^6 + x^5 + 1 Fibonacci form, maximal length (period 63, never reaches 0)
  localparam int LFSR_W     = 6;
  localparam int LFSR_TAP_A = 5;
  localparam int LFSR_TAP_B = 4;

  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/hangy_debounce.sv
// Synchronizer plus counting debouncer for one button; reports the settled
// level and a strobe on the edge where that level rises.
module hangy_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  // Any agreeing cycle restarts the count, so only an unbroken run flips the level
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_o   = 1'b0;
    if (btn_s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = btn_s;
        rise_o   = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/hangy_input_frontend.sv
// Builds the game core's chip_input bus: one-cycle next pulse per accepted
// press, character and random word index latched on that same edge.
module hangy_input_frontend
  import hangy_pkg::*;
#(
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter int                HOLDOFF_CYCLES  = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 6'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next_raw,
  input  logic [CHAR_W-1:0] char_raw,
  output logic [CHIP_W-1:0] chip_input,
  output logic              busy,
  output logic              drop_pulse
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [LFSR_W-1:0] LFSR_INIT = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  logic                                btn_stable, btn_rise, press;
  logic [SYNC_STAGES-1:0][CHAR_W-1:0]  char_sync_q;
  logic [CHAR_W-1:0]                   char_s;
  logic [CHAR_W-1:0]                   char_q, char_d;
  logic [WIDX_W-1:0]                   widx_q, widx_d;
  logic                                next_q, next_d;
  logic                                drop_q, drop_d;
  logic                                busy_q, busy_d;
  logic [HOLD_W-1:0]                   holdoff_q, holdoff_d;
  logic [LFSR_W-1:0]                   lfsr_q, lfsr_d;

  hangy_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (btn_next_raw),
    .stable_o(btn_stable),
    .rise_o  (btn_rise)
  );

  assign char_s = char_sync_q[SYNC_STAGES-1];
  assign press  = btn_rise & ~btn_stable;

  // Holdoff spans the core's guess processing; presses inside it are reported, not forwarded
  always_comb begin
    lfsr_d    = lfsrNext(lfsr_q);
    holdoff_d = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;
    char_d    = char_q;
    widx_d    = widx_q;
    next_d    = 1'b0;
    drop_d    = 1'b0;
    if (press) begin
      if (holdoff_q == '0) begin
        next_d    = 1'b1;
        char_d    = char_s;
        widx_d    = lfsr_q;
        holdoff_d = HOLD_LOAD;
      end else begin
        drop_d = 1'b1;
      end
    end
    busy_d = (holdoff_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_sync_q <= '0;
      char_q      <= '0;
      widx_q      <= '0;
      next_q      <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      holdoff_q   <= '0;
      lfsr_q      <= LFSR_INIT;
    end else begin
      char_sync_q <= {char_sync_q[SYNC_STAGES-2:0], char_raw};
      char_q      <= char_d;
      widx_q      <= widx_d;
      next_q      <= next_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      holdoff_q   <= holdoff_d;
      lfsr_q      <= lfsr_d;
    end
  end

  always_comb begin
    chip_input                         = '0;
    chip_input[CHAR_LSB +: CHAR_W]     = char_q;
    chip_input[NEXT_BIT]               = next_q;
    chip_input[WIDX_LSB +: WIDX_W]     = widx_q;
  end

  assign busy       = busy_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_hangy_input_frontend.sv
// Self-checking bench for hangy_input_frontend: table of presses plus
// hand-written bounce, hold, LFSR and asynchronous-reset sequences.
module tb_hangy_input_frontend;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int LAT  = SYNC + DEB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next_raw = 1'b0;
  logic [4:0]  char_raw = '0;
  logic [11:0] chip_input, chip_input0;
  logic        busy, busy0, drop_pulse, drop_pulse0;

  int compared = 0;
  int mismatched = 0;
  int edgeCnt;
  logic [4:0] lastAccChar = '0;

  typedef struct {
    int         edgeNo;
    logic [4:0] ch;
    logic [5:0] widx;
  } exp_t;

  typedef struct {
    logic [4:0] ch;
    int         hold;
    int         gap;
    bit         accept;
  } vec_t;

  exp_t nextQ[$];
  exp_t dropQ[$];

  hangy_input_frontend #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .LFSR_SEED(6'h01)
  ) dut (
    .clk(clk), .reset(reset), .btn_next_raw(btn_next_raw), .char_raw(char_raw),
    .chip_input(chip_input), .busy(busy), .drop_pulse(drop_pulse)
  );

  hangy_input_frontend #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .LFSR_SEED(6'h00)
  ) dut0 (
    .clk(clk), .reset(reset), .btn_next_raw(btn_next_raw), .char_raw(char_raw),
    .chip_input(chip_input0), .busy(busy0), .drop_pulse(drop_pulse0)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen since reset was last released
  always @(posedge clk or posedge reset) begin
    if (reset) edgeCnt <= 0;
    else       edgeCnt <= edgeCnt + 1;
  end

  function automatic logic [5:0] lfsrAt(input int n);
    logic [5:0] s;
    s = 6'h01;
    for (int i = 0; i < n % 63; i++) s = {s[4:0], s[5] ^ s[4]};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  task automatic pushNext(input int c, input logic [4:0] ch);
    exp_t e;
    e.edgeNo = c + LAT;
    e.ch     = ch;
    e.widx   = lfsrAt(c + LAT - 1);
    nextQ.push_back(e);
    lastAccChar = ch;
  endtask

  task automatic pushDrop(input int c);
    exp_t e;
    e.edgeNo = c + LAT;
    e.ch     = lastAccChar;
    e.widx   = '0;
    dropQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [4:0] ch, input int hold, input int gap, input bit accept);
    @(negedge clk);
    char_raw     = ch;
    btn_next_raw = 1'b1;
    if (accept) pushNext(edgeCnt, ch);
    else        pushDrop(edgeCnt);
    repeat (hold) @(negedge clk);
    btn_next_raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Scoreboard side: every pulse the DUT produces must match a queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (chip_input[5]) begin
        if (nextQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_next: got next=1 expected none (edge %0d)", edgeCnt);
        end else begin
          e = nextQ.pop_front();
          checkOutput("next_edge", edgeCnt, e.edgeNo);
          checkOutput("next_char", chip_input[4:0], e.ch);
          checkOutput("next_widx", chip_input[11:6], e.widx);
          checkOutput("seed0_widx", chip_input0[11:6], e.widx);
          checkOutput("busy_at_accept", busy, 1);
        end
      end
      if (drop_pulse) begin
        if (dropQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_drop: got drop=1 expected none (edge %0d)", edgeCnt);
        end else begin
          e = dropQ.pop_front();
          checkOutput("drop_edge", edgeCnt, e.edgeNo);
          checkOutput("drop_char_kept", chip_input[4:0], e.ch);
          checkOutput("drop_no_next", chip_input[5], 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   c;

    vecs[0] = '{5'd19, 6, 13, 1'b1};
    vecs[1] = '{5'd3,  6,  6, 1'b1};
    vecs[2] = '{5'd12, 6, 40, 1'b0};
    vecs[3] = '{5'd31, 10, 9, 1'b1};
    vecs[4] = '{5'd5,  7,  8, 1'b1};
    vecs[5] = '{5'd22, 5, 30, 1'b0};
    vecs[6] = '{5'd17, 6, 10, 1'b1};
    vecs[7] = '{5'd9,  6, 20, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_chip_input", chip_input, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_drop", drop_pulse, 0);
    checkOutput("reset_lfsr", dut.lfsr_q, 6'h01);
    checkOutput("reset_lfsr_seed0", dut0.lfsr_q, 6'h01);

    // Clean step right at reset release: accept on edge LAT, busy for HOLD cycles
    reset        = 1'b0;
    char_raw     = 5'd7;
    btn_next_raw = 1'b1;
    pushNext(edgeCnt, 5'd7);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      checkOutput("busy_window", busy, (edgeCnt >= LAT && edgeCnt <= LAT + HOLD - 1));
      if (i == 10) btn_next_raw = 1'b0;
    end
    repeat (10) @(negedge clk);

    for (int v = 0; v < 8; v++) applyStimulus(vecs[v].ch, vecs[v].hold, vecs[v].gap, vecs[v].accept);

    // Bouncy press: only the final settled rise counts
    @(negedge clk);
    char_raw = 5'd21;
    btn_next_raw = 1'b1; repeat (2) @(negedge clk);
    btn_next_raw = 1'b0; repeat (2) @(negedge clk);
    btn_next_raw = 1'b1; repeat (2) @(negedge clk);
    btn_next_raw = 1'b0; repeat (2) @(negedge clk);
    btn_next_raw = 1'b1;
    pushNext(edgeCnt, 5'd21);
    repeat (12) @(negedge clk);
    btn_next_raw = 1'b0;
    repeat (25) @(negedge clk);

    // Long hold with a wandering char_raw: one pulse, latched char stays put
    @(negedge clk);
    char_raw     = 5'd9;
    btn_next_raw = 1'b1;
    pushNext(edgeCnt, 5'd9);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i > LAT + 2) char_raw = 5'($urandom);
      if (i % 40 == 0) checkOutput("held_char", chip_input[4:0], 5'd9);
      if (i == 100) checkOutput("held_busy_clear", busy, 0);
    end
    btn_next_raw = 1'b0;
    char_raw     = '0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      checkOutput("lfsr_model", dut.lfsr_q, lfsrAt(edgeCnt));
      checkOutput("lfsr_nonzero", (dut.lfsr_q != 6'h00), 1);
      checkOutput("lfsr_seed0", dut0.lfsr_q, lfsrAt(edgeCnt));
    end

    // Asynchronous reset in the middle of a holdoff window
    @(negedge clk);
    char_raw     = 5'd4;
    btn_next_raw = 1'b1;
    c = edgeCnt;
    pushNext(c, 5'd4);
    repeat (LAT + 3) @(negedge clk);
    checkOutput("busy_before_reset", busy, 1);
    checkOutput("pending_before_reset", nextQ.size(), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_chip_input", chip_input, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_drop", drop_pulse, 0);
    checkOutput("async_rst_lfsr", dut.lfsr_q, 6'h01);
    checkOutput("async_rst_lfsr_seed0", dut0.lfsr_q, 6'h01);
    btn_next_raw = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset while a press is still being debounced
    @(negedge clk);
    btn_next_raw = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("debounce_rst_chip_input", chip_input, 0);
    checkOutput("debounce_rst_busy", busy, 0);
    btn_next_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("quiet_after_reset", chip_input, 0);

    applyStimulus(5'd26, 8, 20, 1'b1);

    repeat (10) @(negedge clk);
    checkOutput("pending_next", nextQ.size(), 0);
    checkOutput("pending_drop", dropQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hangy_input_frontend.md
Name: hangy_input_frontend

Overview:
- Sits directly upstream of the hangman game core. Produces its 12-bit chip_input bus from raw pad signals.
- Synchronizes and debounces the raw "next" button and emits exactly one single-cycle next pulse per accepted press. The core needs a one-cycle pulse because a held level would skip it through INIT/GEN_WORD/GUESS.
- Latches the guessed character with each accepted press, so chip_input[4:0] stays stable through the core's CHECK/CORRECT sequence.
- Supplies a pseudo-random 6-bit word index from a free-running LFSR, captured at each accepted press.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (>=2).
- DEBOUNCE_CYCLES, 16, consecutive disagreeing cycles required before the debounced button level changes (>=2).
- HOLDOFF_CYCLES, 16, cycles after an accepted press during which new presses are dropped (>=12, covering the core's worst-case guess processing).
- LFSR_SEED, 6'h01, LFSR reset value; a value of 0 is replaced by 6'h01.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_next_raw  input  1  raw, bouncy next button, asynchronous to clk
- char_raw  input  5  raw letter code, asynchronous to clk
- chip_input  output  12  {word_idx_q[5:0], next_q, char_q[4:0]}, i.e. bits 11:6 word index, bit 5 next, bits 4:0 character
- busy  output  1  high while the holdoff counter is nonzero
- drop_pulse  output  1  one-cycle pulse when a debounced press is rejected because busy is high

Behaviour:
- Reset is asynchronous and active-high: every flop clears immediately, independent of clk.
- Reset values:
  - synchronizers 0, debounced level stable=0, debounce counter 0, holdoff counter 0
  - lfsr=LFSR_SEED
  - char_q=0, word_idx_q=0, next_q=0
  - busy=0, drop_pulse=0
- Synchronizers: btn_next_raw and each char_raw bit pass through SYNC_STAGES flops, giving btn_s and char_s.
- Debounce:
  - The counter increments each cycle btn_s != stable.
  - The counter clears on any cycle btn_s == stable.
  - If count==DEBOUNCE_CYCLES-1 and disagreement persists, stable <= btn_s and the counter clears.
- Press event: stable flipping 0->1 on this edge (rise).
- Accept: rise && holdoff==0. On the same edge:
  - next_q<=1, char_q<=char_s, word_idx_q<=lfsr (current value)
  - holdoff<=HOLDOFF_CYCLES
- Drop: rise && holdoff!=0. drop_pulse<=1; char_q, word_idx_q and holdoff are unchanged.
- next_q and drop_pulse are 1 for exactly one cycle. Otherwise they are 0.
- Holdoff decrements by 1 per cycle while nonzero. busy = (holdoff!=0), registered value.
- A holdoff reaching 0 on edge N permits an accept on edge N+1.
- Latency: a clean raw 0->1 step is followed by next_q=1 after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
- char_raw must be stable for >=SYNC_STAGES cycles before the accept edge. Multi-bit skew outside that window is harmless.
- Held button: only one pulse per 0->1 debounced transition. Release plus re-press is a new event, subject to holdoff.
- Bounces shorter than DEBOUNCE_CYCLES produce no event. A release also needs DEBOUNCE_CYCLES agreeing cycles.
- LFSR:
  - 6-bit Fibonacci, x^6+x^5+1, advances every cycle: lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - Period is 63. It never reaches 0, so word index 0 is never produced.
- Button held through reset deassertion: it is treated as a new press after SYNC_STAGES+DEBOUNCE_CYCLES cycles. This is intended.
- Reset mid-operation: a pending pulse, holdoff or debounce count is discarded.

Decomposition:
- Shared package hangy_pkg:
  - chip_input field constants: CHAR_LSB=0, CHAR_W=5, NEXT_BIT=5, WIDX_LSB=6, WIDX_W=6
  - LFSR tap constants
- One natural sub-module: hangy_debounce.
  - Contains the synchronizer, debounce counter and stable level, and outputs stable plus a rise strobe.
  - Instantiated once for the button.
  - The char bits use plain synchronizer flops only.

Test Plan:
- SYNC=2, DEBOUNCE=4: reset, char_raw=5'd7, clean btn 0->1 before edge 0 -> next_q=1 only after edge 6 for one cycle, chip_input[4:0]=7, busy=1 from edge 6.
- Bouncy press: btn toggles 1,0,1,0 with 2-cycle periods, then stays 1 -> exactly one next pulse, DEBOUNCE cycles after the final rise settles; no pulse for the glitches.
- Holdoff: HOLDOFF=16, second clean press whose debounced rise lands 5 cycles after the first accept -> drop_pulse=1, no next_q, char_q keeps its first value. A press landing after busy falls -> accepted.
- Button held 200 cycles -> exactly one next_q pulse; chip_input[4:0] holds its latched value while char_raw changes.
- LFSR: seed 6'h01, accept on known cycle k -> word_idx_q equals reference-model LFSR at k; the free-running sequence repeats with period 63 and never shows 0. Seed 0 -> behaves as 6'h01.
- Assert reset asynchronously mid-holdoff and mid-debounce (between clk edges) -> all outputs 0 and lfsr=seed immediately, no pulse after release until a fresh debounced press.
